video_rx: RTL and testbench

VIDEO_RX -- requirements
Module: video_rx

---
 rtl/video_rx_pkg.sv | 13 +
 rtl/video_rx_if.sv | 38 +++
 rtl/video_rx_stats.sv | 96 +++++++++
 rtl/video_rx.sv | 147 ++++++++++++++
 tb/tb_video_rx.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/video_rx_pkg.sv
// Shared types for the video receiver: capture FSM states and the packed pixel colour.
package video_rx_pkg;

  typedef enum logic {
    SEARCH  = 1'b0,
    CAPTURE = 1'b1
  } rx_state_e;

  localparam int RGB_W = 24;

  typedef logic [RGB_W-1:0] rgb_t;

endpackage

// File: rtl/video_rx_if.sv
// Video receiver bundle: raw sync/pixel input, captured pixel stream and per-frame statistics.
interface video_rx_if #(
  parameter int X_W = 11,
  parameter int Y_W = 10
);
  import video_rx_pkg::*;

  logic           hs;
  logic           vs;
  logic           blank_n;
  rgb_t           rgb;

  logic           pix_valid;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  rgb_t           pix_rgb;
  logic           pix_sof;

  logic           frame_done;
  logic [X_W-1:0] frame_width;
  logic [Y_W-1:0] frame_height;
  logic [31:0]    frame_sum;
  logic           err_width;
  logic           err_sync;

  modport master (
    output hs, vs, blank_n, rgb,
    input  pix_valid, pix_x, pix_y, pix_rgb, pix_sof,
    input  frame_done, frame_width, frame_height, frame_sum, err_width, err_sync
  );

  modport slave (
    input  hs, vs, blank_n, rgb,
    output pix_valid, pix_x, pix_y, pix_rgb, pix_sof,
    output frame_done, frame_width, frame_height, frame_sum, err_width, err_sync
  );

endinterface

// File: rtl/video_rx_stats.sv
// Per-frame statistics: first-line width, line count, colour sum and error flags,
// published with a one-cycle frame_done and held until the next frame completes.
module video_rx_stats
  import video_rx_pkg::*;
#(
  parameter int X_W = 11,
  parameter int Y_W = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           frame_end,
  input  logic           pix_en,
  input  rgb_t           pix_rgb,
  input  logic           eol,
  input  logic [X_W-1:0] run_len,
  input  logic           sync_err,
  output logic           frame_done,
  output logic [X_W-1:0] frame_width,
  output logic [Y_W-1:0] frame_height,
  output logic [31:0]    frame_sum,
  output logic           err_width,
  output logic           err_sync
);

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [X_W-1:0] width_acc_q, width_acc_d;
  logic [Y_W-1:0] height_acc_q, height_acc_d;
  logic [31:0]    sum_acc_q, sum_acc_d;
  logic           errw_acc_q, errw_acc_d;
  logic           errs_acc_q, errs_acc_d;

  always_comb begin
    width_acc_d  = width_acc_q;
    height_acc_d = height_acc_q;
    sum_acc_d    = sum_acc_q;
    errw_acc_d   = errw_acc_q;
    errs_acc_d   = errs_acc_q;
    if (clear) begin
      // a sync error on the clearing edge itself belongs to the frame that starts here
      width_acc_d  = '0;
      height_acc_d = '0;
      sum_acc_d    = '0;
      errw_acc_d   = 1'b0;
      errs_acc_d   = sync_err;
    end else begin
      if (pix_en) begin
        sum_acc_d = sum_acc_q + {8'h00, pix_rgb};
      end
      if (eol) begin
        if (height_acc_q == '0) begin
          width_acc_d = run_len;
        end else if (run_len != width_acc_q) begin
          errw_acc_d = 1'b1;
        end
        height_acc_d = sat_inc_y(height_acc_q);
      end
      if (sync_err) begin
        errs_acc_d = 1'b1;
      end
    end
  end

  // accumulators are always cleared by the vs edge that opens capture, so they carry no reset
  always_ff @(posedge clk) begin
    width_acc_q  <= width_acc_d;
    height_acc_q <= height_acc_d;
    sum_acc_q    <= sum_acc_d;
    errw_acc_q   <= errw_acc_d;
    errs_acc_q   <= errs_acc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_done   <= 1'b0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_sum    <= '0;
      err_width    <= 1'b0;
      err_sync     <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        frame_width  <= width_acc_q;
        frame_height <= height_acc_q;
        frame_sum    <= sum_acc_q;
        err_width    <= errw_acc_q;
        err_sync     <= errs_acc_q;
      end
    end
  end

endmodule

// File: rtl/video_rx.sv
// Video capture front end: registers raw sync/pixel input, tracks x/y through a
// SEARCH/CAPTURE FSM and emits a coordinate-tagged pixel stream plus frame statistics.
module video_rx
  import video_rx_pkg::*;
#(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int X_W             = 11,
  parameter int Y_W             = 10
) (
  input logic        clk,
  input logic        reset,
  video_rx_if.slave  bus
);

  localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW;

  function automatic logic [X_W-1:0] sat_inc_x(input logic [X_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic           hs_p0, vs_p0, blank_n_p0;
  rgb_t           rgb_p0;
  rx_state_e      state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           run_q, run_d;
  logic           vs_prev_q, vs_prev_d;
  logic           hs_act, vs_act, vs_edge, capturing;
  logic           pixel, eol, sync_err, frame_end;
  logic           vld_p1, sof_p1;
  logic [X_W-1:0] pix_x_p1;
  logic [Y_W-1:0] pix_y_p1;
  rgb_t           rgb_p1;

  // stage p0: input registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_p0      <= SYNC_IDLE;
      vs_p0      <= SYNC_IDLE;
      blank_n_p0 <= 1'b0;
    end else begin
      hs_p0      <= bus.hs;
      vs_p0      <= bus.vs;
      blank_n_p0 <= bus.blank_n;
    end
  end

  always_ff @(posedge clk) begin
    rgb_p0 <= bus.rgb;
  end

  always_comb begin
    hs_act    = hs_p0 ^ SYNC_IDLE;
    vs_act    = vs_p0 ^ SYNC_IDLE;
    vs_edge   = vs_act & ~vs_prev_q;
    capturing = (state_q == CAPTURE);
    pixel     = capturing & blank_n_p0 & ~hs_act & ~vs_act;
    eol       = capturing & ~blank_n_p0 & run_q;
    sync_err  = capturing & blank_n_p0 & (hs_act | vs_act);
    frame_end = vs_edge & capturing & (y_q != '0);

    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    run_d     = run_q;
    vs_prev_d = vs_act;
    if (vs_edge) begin
      state_d = CAPTURE;
      x_d     = '0;
      y_d     = '0;
      run_d   = 1'b0;
    end else if (pixel) begin
      x_d   = sat_inc_x(x_q);
      run_d = 1'b1;
    end else if (eol) begin
      x_d   = '0;
      y_d   = sat_inc_y(y_q);
      run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      x_q       <= '0;
      y_q       <= '0;
      run_q     <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      run_q     <= run_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  // stage p1: pixel output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
    end else begin
      vld_p1 <= pixel;
      sof_p1 <= pixel & (x_q == '0) & (y_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    pix_x_p1 <= x_q;
    pix_y_p1 <= y_q;
    rgb_p1   <= rgb_p0;
  end

  // data registers are unreset, so coordinates and colour are qualified by valid
  assign bus.pix_valid = vld_p1;
  assign bus.pix_sof   = sof_p1;
  assign bus.pix_x     = vld_p1 ? pix_x_p1 : '0;
  assign bus.pix_y     = vld_p1 ? pix_y_p1 : '0;
  assign bus.pix_rgb   = vld_p1 ? rgb_p1 : '0;

  video_rx_stats #(
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_stats (
    .clk         (clk),
    .reset       (reset),
    .clear       (vs_edge),
    .frame_end   (frame_end),
    .pix_en      (pixel),
    .pix_rgb     (rgb_p0),
    .eol         (eol),
    .run_len     (x_q),
    .sync_err    (sync_err),
    .frame_done  (bus.frame_done),
    .frame_width (bus.frame_width),
    .frame_height(bus.frame_height),
    .frame_sum   (bus.frame_sum),
    .err_width   (bus.err_width),
    .err_sync    (bus.err_sync)
  );

endmodule

// File: tb/tb_video_rx.sv
// Directed bench for video_rx on a reduced 20x6 raster: a table of frame scenarios with
// hand-computed statistics, a pixel scoreboard, and reset / positive-sync corner sequences.
module tb_video_rx;
  import video_rx_pkg::*;

  localparam int X_W = 11, Y_W = 10, X2_W = 4;
  localparam int H_ACT = 20, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACT = 6, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam logic [31:0] SUM_CONST = 32'd120;       // 120 pixels of 0x000001
  localparam logic [31:0] SUM_PAT   = 32'd74787840;  // 1140*65536 + 300*256
  localparam int N_REC = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  video_rx_if #(.X_W(X_W),  .Y_W(Y_W)) bus ();
  video_rx_if #(.X_W(X2_W), .Y_W(Y_W)) bus2 ();

  video_rx #(.SYNC_ACTIVE_LOW(1'b1), .X_W(X_W), .Y_W(Y_W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  video_rx #(.SYNC_ACTIVE_LOW(1'b0), .X_W(X2_W), .Y_W(Y_W)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  assign bus2.hs      = ~bus.hs;
  assign bus2.vs      = ~bus.vs;
  assign bus2.blank_n = bus.blank_n;
  assign bus2.rgb     = bus.rgb;

  int n_chk = 0, n_pass = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  typedef struct {
    int          cyc;
    int          x;
    int          y;
    logic [23:0] rgb;
  } pexp_t;

  typedef struct {
    int          short_line;
    int          err_line;
    bit          pat;
    bit          vpix;
    int          exp_w;
    int          exp_h;
    logic [31:0] exp_sum;
    bit          exp_ew;
    bit          exp_es;
  } rec_t;

  pexp_t pq[$];
  bit    capturing = 1'b0;
  logic  last_vs = 1'b1;

  int             done_cnt = 0, done2_cnt = 0;
  bit             prev_done = 1'b0;
  logic [X_W-1:0] d_w;
  logic [Y_W-1:0] d_h;
  logic [31:0]    d_sum;
  logic           d_ew, d_es;
  logic [X2_W-1:0] d2_w;
  logic [Y_W-1:0]  d2_h;
  logic [31:0]     d2_sum;
  logic            d2_ew, d2_es;

  function automatic logic [23:0] color(input int x, input int y, input bit pat);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    return pat ? {xb, yb, 8'h00} : 24'h000001;
  endfunction

  task automatic tick(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb,
                      input bit push, input int x, input int y);
    pexp_t pe;
    bus.hs = hs; bus.vs = vs; bus.blank_n = bl; bus.rgb = rgb;
    if (vs == 1'b0 && last_vs == 1'b1) capturing = 1'b1;
    last_vs = vs;
    if (push && capturing) begin
      pe.cyc = cyc; pe.x = x; pe.y = y; pe.rgb = rgb;
      pq.push_back(pe);
    end
    @(negedge clk);
  endtask

  task automatic drive_line(input bit act, input bit vsl, input int npix, input int y,
                            input bit pat, input bit serr, input bit vpix);
    logic vsv;
    vsv = vsl ? 1'b0 : 1'b1;
    for (int c = 0; c < H_ACT; c++) begin
      if (act && c < npix)    tick(1'b1, vsv, 1'b1, color(c, y, pat), 1'b1, c, y);
      else if (vpix && c == 0) tick(1'b1, vsv, 1'b1, 24'hABCDEF, 1'b0, 0, 0);
      else                    tick(1'b1, vsv, 1'b0, 24'h0, 1'b0, 0, 0);
    end
    for (int c = 0; c < H_FP; c++) tick(1'b1, vsv, 1'b0, 24'h0, 1'b0, 0, 0);
    for (int c = 0; c < H_SYNC; c++) tick(1'b0, vsv, serr, serr ? 24'hFFFFFF : 24'h0, 1'b0, 0, 0);
    for (int c = 0; c < H_BP; c++) tick(1'b1, vsv, 1'b0, 24'h0, 1'b0, 0, 0);
  endtask

  task automatic drive_frame(input rec_t r);
    for (int l = 0; l < V_ACT; l++)
      drive_line(1'b1, 1'b0, (l == r.short_line) ? H_ACT - 1 : H_ACT, l, r.pat, l == r.err_line, 1'b0);
    for (int l = 0; l < V_FP; l++) drive_line(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < V_SYNC; l++) drive_line(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, (l == 0) && r.vpix);
    for (int l = 0; l < V_BP; l++) drive_line(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    pexp_t pe;
    forever begin
      @(negedge clk);
      while (pq.size() > 0 && pq[0].cyc + 2 < cyc) begin
        chk("pix_missing", 64'(cyc), 64'(pq[0].cyc + 2));
        pq.delete(0);
      end
      if (bus.pix_valid) begin
        if (pq.size() == 0) begin
          chk("pix_unexpected", 64'(bus.pix_valid), 64'd0);
        end else begin
          pe = pq.pop_front();
          chk("pix_latency", 64'(cyc - pe.cyc), 64'd2);
          chk("pix_data", 64'({16'(bus.pix_x), 16'(bus.pix_y), bus.pix_rgb, bus.pix_sof}),
              64'({16'(pe.x), 16'(pe.y), pe.rgb, (pe.x == 0 && pe.y == 0)}));
        end
      end
      if (prev_done) chk("done_one_cycle", 64'(bus.frame_done), 64'd0);
      prev_done = bus.frame_done;
      if (bus.frame_done) begin
        done_cnt++;
        d_w = bus.frame_width; d_h = bus.frame_height; d_sum = bus.frame_sum;
        d_ew = bus.err_width; d_es = bus.err_sync;
      end
      if (bus2.frame_done) begin
        done2_cnt++;
        d2_w = bus2.frame_width; d2_h = bus2.frame_height; d2_sum = bus2.frame_sum;
        d2_ew = bus2.err_width; d2_es = bus2.err_sync;
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_pix"}, 64'({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb, bus.pix_sof, bus.frame_done}), 64'd0);
    chk({tag, "_stats"}, 64'({bus.frame_width, bus.frame_height, bus.err_width, bus.err_sync}), 64'd0);
    chk({tag, "_sum"}, 64'(bus.frame_sum), 64'd0);
  endtask

  task automatic check_done(input string tag, input rec_t r);
    chk({tag, "_dims"}, 64'({16'(d_w), 16'(d_h)}), 64'({16'(r.exp_w), 16'(r.exp_h)}));
    chk({tag, "_sum"}, 64'(d_sum), 64'(r.exp_sum));
    chk({tag, "_errs"}, 64'({d_ew, d_es}), 64'({r.exp_ew, r.exp_es}));
    chk({tag, "_hold"}, 64'({16'(bus.frame_width), 16'(bus.frame_height), bus.frame_sum}),
        64'({16'(r.exp_w), 16'(r.exp_h), r.exp_sum}));
  endtask

  initial begin
    rec_t tbl[N_REC];
    rec_t clean;
    int   base, base2;

    //          short err pat vpix  w   h   sum        ew es
    tbl[0] = '{-1, -1, 1'b0, 1'b0, 20, 6, SUM_CONST, 1'b0, 1'b0};
    tbl[1] = '{-1, -1, 1'b1, 1'b0, 20, 6, SUM_PAT,   1'b0, 1'b0};
    tbl[2] = '{ 2, -1, 1'b0, 1'b0, 20, 6, 32'd119,   1'b1, 1'b0};
    tbl[3] = '{-1, -1, 1'b0, 1'b0, 20, 6, SUM_CONST, 1'b0, 1'b0};
    tbl[4] = '{-1,  3, 1'b0, 1'b0, 20, 6, SUM_CONST, 1'b0, 1'b1};
    tbl[5] = '{-1, -1, 1'b1, 1'b0, 20, 6, SUM_PAT,   1'b0, 1'b0};
    tbl[6] = '{-1, -1, 1'b0, 1'b1, 20, 6, SUM_CONST, 1'b0, 1'b0};
    tbl[7] = '{-1, -1, 1'b0, 1'b0, 20, 6, SUM_CONST, 1'b0, 1'b1};
    clean  = '{-1, -1, 1'b0, 1'b0, 20, 6, SUM_CONST, 1'b0, 1'b0};

    bus.hs = 1'b1; bus.vs = 1'b1; bus.blank_n = 1'b0; bus.rgb = 24'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    drive_frame(clean);
    chk("search_no_done", 64'(done_cnt), 64'd0);

    for (int i = 0; i < N_REC; i++) begin
      base = done_cnt;
      drive_frame(tbl[i]);
      chk($sformatf("rec%0d_done_cnt", i), 64'(done_cnt), 64'(base + 1));
      check_done($sformatf("rec%0d", i), tbl[i]);
    end

    chk("pos_done_cnt", 64'(done2_cnt), 64'(N_REC));
    chk("pos_dims_sat", 64'({16'(d2_w), 16'(d2_h)}), 64'({16'd15, 16'd6}));
    chk("pos_sum_errs", 64'({d2_sum, d2_ew, d2_es}), 64'({32'd120, 1'b0, 1'b1}));

    for (int l = 0; l < 3; l++) drive_line(1'b1, 1'b0, H_ACT, l, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    capturing = 1'b0;
    last_vs = 1'b1;
    pq.delete();
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    base  = done_cnt;
    base2 = done2_cnt;
    drive_frame(clean);
    chk("postreset_first_edge_no_done", 64'(done_cnt), 64'(base));
    drive_frame(clean);
    chk("postreset_done_cnt", 64'(done_cnt), 64'(base + 1));
    check_done("postreset", clean);
    chk("pos_postreset_done_cnt", 64'(done2_cnt), 64'(base2 + 1));
    chk("pos_postreset_dims", 64'({16'(d2_w), 16'(d2_h)}), 64'({16'd15, 16'd6}));

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
